pulse_delay_ctrl: RTL and testbench

Programmable trigger-to-pulse scheduler. It detects the rising edge of a trigger, waits a run-time-configurable number of clocks, then emits a pulse of configurable width, followed by a fixed hold-off. It replaces fixed-tap shift-register delays wherever the delay or width must be set from the register interface. It also counts triggers dropped while busy, for diagnostics.

---
 rtl/pulse_delay_pkg.sv | 29 ++
 rtl/rise_edge_det.sv | 29 ++
 rtl/pulse_delay_ctrl.sv | 140 ++++++++++++++
 tb/tb_pulse_delay_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_delay_pkg.sv
// pulse_delay_pkg
// Shared types and constants for the programmable trigger-to-pulse scheduler:
// the FSM state encoding, the config register reset values, the width of the
// missed-trigger counter and its saturating increment helper.
package pulse_delay_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DELAY = 2'd1,
      PULSE = 2'd2,
      HOLD  = 2'd3
   } state_e;

   localparam int DLY_RST = 0;
   localparam int WID_RST = 1;
   localparam int MISS_W  = 8;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [MISS_W-1:0] sat_inc(input logic [MISS_W-1:0] v);
      logic [MISS_W-1:0] r;
      if (v == {MISS_W{1'b1}}) begin
         r = v;
      end else begin
         r = v + MISS_W'(1);
      end
      return r;
   endfunction

endpackage

// File: rtl/rise_edge_det.sv
// rise_edge_det
// Rising-edge detector for a signal already synchronous to i_clk.
// Ports:
//   i_clk   - clock
//   i_rst_n - asynchronous active-low reset (history flop clears to 0, so a
//             signal already high at reset release reads as an edge)
//   i_sig   - level input
//   o_edge  - high in the cycle where i_sig is 1 and was 0 on the previous clock
module rise_edge_det (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_sig,
   output logic o_edge
);

   logic r_sig_q;

   // History flop holding last cycle's level.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sig_q <= 1'b0;
      end else begin
         r_sig_q <= i_sig;
      end
   end

   assign o_edge = i_sig & ~r_sig_q;

endmodule

// File: rtl/pulse_delay_ctrl.sv
// pulse_delay_ctrl
// Detects the rising edge of a trigger, waits a programmable number of clocks,
// emits a pulse of programmable width, then enforces a fixed hold-off.
// Triggers arriving while busy are dropped and counted.
// Ports:
//   i_clk, i_rst_n           - clock, asynchronous active-low reset
//   i_trig_in                - trigger level (rising edges act)
//   i_cfg_wr                 - strobe loading i_cfg_delay / i_cfg_width
//   i_cfg_delay, i_cfg_width - delay and pulse width in clocks (width 0 -> 1)
//   i_miss_clr               - synchronous clear of o_miss_cnt
//   o_pulse_out              - delayed pulse, straight from a flop
//   o_busy                   - high whenever the scheduler is not idle
//   o_cfg_ack                - one-cycle acknowledge of an accepted write
//   o_miss_cnt               - saturating count of triggers ignored while busy
module pulse_delay_ctrl
   import pulse_delay_pkg::*;
#(
   parameter int CNT_W   = 8,
   parameter int HOLDOFF = 2
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_trig_in,
   input  logic              i_cfg_wr,
   input  logic [CNT_W-1:0]  i_cfg_delay,
   input  logic [CNT_W-1:0]  i_cfg_width,
   input  logic              i_miss_clr,
   output logic              o_pulse_out,
   output logic              o_busy,
   output logic              o_cfg_ack,
   output logic [MISS_W-1:0] o_miss_cnt
);

   logic              w_edge;
   state_e            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  r_delay;
   logic [CNT_W-1:0]  r_width;
   logic              r_pulse;
   logic              r_ack;
   logic [MISS_W-1:0] r_miss;

   rise_edge_det u_trig_edge (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_sig   (i_trig_in),
      .o_edge  (w_edge)
   );

   // Scheduler FSM with its down-counter, config registers and the
   // registered pulse/ack outputs. Config only changes in IDLE, so a pulse
   // in flight always sees the values latched through the counter loads.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
         r_cnt   <= {CNT_W{1'b0}};
         r_delay <= CNT_W'(DLY_RST);
         r_width <= CNT_W'(WID_RST);
         r_pulse <= 1'b0;
         r_ack   <= 1'b0;
      end else begin
         r_ack <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_edge) begin
                  // A trigger beats a coincident write; old values are used.
                  if (r_delay != {CNT_W{1'b0}}) begin
                     r_state <= DELAY;
                     r_cnt   <= r_delay - CNT_W'(1);
                     r_pulse <= 1'b0;
                  end else begin
                     r_state <= PULSE;
                     r_cnt   <= r_width - CNT_W'(1);
                     r_pulse <= 1'b1;
                  end
               end else if (i_cfg_wr) begin
                  r_delay <= i_cfg_delay;
                  r_width <= (i_cfg_width == {CNT_W{1'b0}}) ? CNT_W'(1) : i_cfg_width;
                  r_ack   <= 1'b1;
                  r_pulse <= 1'b0;
               end else begin
                  r_pulse <= 1'b0;
               end
            end
            DELAY: begin
               if (r_cnt != {CNT_W{1'b0}}) begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end else begin
                  r_state <= PULSE;
                  r_cnt   <= r_width - CNT_W'(1);
                  r_pulse <= 1'b1;
               end
            end
            PULSE: begin
               if (r_cnt != {CNT_W{1'b0}}) begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end else if (HOLDOFF == 0) begin
                  r_state <= IDLE;
                  r_pulse <= 1'b0;
               end else begin
                  r_state <= HOLD;
                  r_cnt   <= CNT_W'(HOLDOFF - 1);
                  r_pulse <= 1'b0;
               end
            end
            HOLD: begin
               if (r_cnt != {CNT_W{1'b0}}) begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end else begin
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= {CNT_W{1'b0}};
               r_pulse <= 1'b0;
            end
         endcase
      end
   end

   // Missed-trigger counter; a clear takes priority over a same-cycle miss.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_miss <= {MISS_W{1'b0}};
      end else if (i_miss_clr) begin
         r_miss <= {MISS_W{1'b0}};
      end else if (w_edge && (r_state != IDLE)) begin
         r_miss <= sat_inc(r_miss);
      end else begin
         r_miss <= r_miss;
      end
   end

   assign o_pulse_out = r_pulse;
   assign o_busy      = (r_state != IDLE);
   assign o_cfg_ack   = r_ack;
   assign o_miss_cnt  = r_miss;

endmodule

// File: tb/tb_pulse_delay_ctrl.sv
// Self-checking bench for pulse_delay_ctrl. The reference model describes each
// accepted trigger as cycle windows (pulse start/end, busy end) computed from
// delay, width and hold-off with plain arithmetic.
module tb_pulse_delay_ctrl;

   localparam int CNT_W   = 8;
   localparam int HOLDOFF = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       trig = 1'b0;
   logic       cfg_wr = 1'b0;
   logic       miss_clr = 1'b0;
   logic [7:0] cfg_delay = 8'd0;
   logic [7:0] cfg_width = 8'd0;
   logic       pulse;
   logic       busy;
   logic       ack;
   logic [7:0] miss;

   int errors = 0;
   int checks = 0;

   // reference model state
   int n;
   bit m_prev;
   int m_d, m_w, m_miss;
   int m_busy_last, m_pf, m_pl;
   bit m_ack;

   pulse_delay_ctrl #(.CNT_W(CNT_W), .HOLDOFF(HOLDOFF)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_trig_in   (trig),
      .i_cfg_wr    (cfg_wr),
      .i_cfg_delay (cfg_delay),
      .i_cfg_width (cfg_width),
      .i_miss_clr  (miss_clr),
      .o_pulse_out (pulse),
      .o_busy      (busy),
      .o_cfg_ack   (ack),
      .o_miss_cnt  (miss)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      n           = 0;
      m_prev      = 1'b0;
      m_d         = 0;
      m_w         = 1;
      m_miss      = 0;
      m_busy_last = -1;
      m_pf        = -1;
      m_pl        = -2;
      m_ack       = 1'b0;
   endtask

   // Expected {pulse, busy, ack, miss} for the cycle after posedge n.
   function automatic logic [10:0] exp_vec();
      logic [7:0] mm;
      mm = m_miss[7:0];
      return {(n >= m_pf && n <= m_pl), (n <= m_busy_last), m_ack, mm};
   endfunction

   // Drive one clock of stimulus, advance the model, return at the negedge.
   task automatic step(input bit t, input bit wr, input logic [7:0] d,
                       input logic [7:0] w, input bit clr);
      bit edg, bpre;
      trig = t; cfg_wr = wr; cfg_delay = d; cfg_width = w; miss_clr = clr;
      @(posedge clk);
      n    = n + 1;
      edg  = t && !m_prev;
      m_prev = t;
      bpre = (n - 1 <= m_busy_last);
      m_ack = 1'b0;
      if (edg && bpre && m_miss < 255) m_miss = m_miss + 1;
      if (clr) m_miss = 0;
      if (!bpre) begin
         if (edg) begin
            m_pf        = n + m_d;
            m_pl        = n + m_d + m_w - 1;
            m_busy_last = n + m_d + m_w + HOLDOFF - 1;
         end else if (wr) begin
            m_d   = int'(d);
            m_w   = (w == 8'd0) ? 1 : int'(w);
            m_ack = 1'b1;
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      int pc, bc;
      #2;
      checks++;
      if ({pulse, busy, ack, miss} !== 11'd0) begin
         errors++;
         $display("FAIL reset_state got=%b exp=%b", {pulse, busy, ack, miss}, 11'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
         checks++;
         if ({pulse, busy, ack, miss} !== exp_vec()) begin
            errors++;
            $display("FAIL reset_idle got=%b exp=%b", {pulse, busy, ack, miss}, exp_vec());
         end
      end
      step(1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
      checks++;
      if (pulse !== 1'b1) begin
         errors++;
         $display("FAIL reset_default_latency got=%b exp=1", pulse);
      end
      pc = int'(pulse); bc = int'(busy);
      for (int k = 0; k < 5; k++) begin
         step(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
         pc += int'(pulse); bc += int'(busy);
         checks++;
         if ({pulse, busy, ack, miss} !== exp_vec()) begin
            errors++;
            $display("FAIL reset_default_seq got=%b exp=%b", {pulse, busy, ack, miss}, exp_vec());
         end
      end
      checks++;
      if (pc != 1 || bc != 3) begin
         errors++;
         $display("FAIL reset_default_counts got=pulse%0d/busy%0d exp=pulse1/busy3", pc, bc);
      end
   endtask

   task automatic test_delay_width();
      int first, pc, bc;
      step(1'b0, 1'b1, 8'd5, 8'd3, 1'b0);
      checks++;
      if (ack !== 1'b1) begin
         errors++;
         $display("FAIL dw_ack got=%b exp=1", ack);
      end
      step(1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
      first = -1; pc = int'(pulse); bc = int'(busy);
      for (int j = 1; j < 14; j++) begin
         step(1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
         if (pulse && first < 0) first = j;
         pc += int'(pulse); bc += int'(busy);
         checks++;
         if ({pulse, busy, ack, miss} !== exp_vec()) begin
            errors++;
            $display("FAIL dw_seq j=%0d got=%b exp=%b", j, {pulse, busy, ack, miss}, exp_vec());
         end
      end
      checks++;
      if (first != 5 || pc != 3 || bc != 10) begin
         errors++;
         $display("FAIL dw_timing got=first%0d/pulse%0d/busy%0d exp=first5/pulse3/busy10",
                  first, pc, bc);
      end
      step(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
   endtask

   task automatic test_width_zero();
      int pc;
      step(1'b0, 1'b1, 8'd0, 8'd0, 1'b0);
      pc = 0;
      for (int j = 0; j < 20; j++) begin
         step(1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
         pc += int'(pulse);
         checks++;
         if ({pulse, busy, ack, miss} !== exp_vec()) begin
            errors++;
            $display("FAIL wz_seq j=%0d got=%b exp=%b", j, {pulse, busy, ack, miss}, exp_vec());
         end
      end
      checks++;
      if (pc != 1) begin
         errors++;
         $display("FAIL wz_one_pulse got=%0d exp=1", pc);
      end
      step(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
   endtask

   task automatic test_write_block();
      int first;
      step(1'b0, 1'b1, 8'd2, 8'd1, 1'b0);
      step(1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
      step(1'b1, 1'b1, 8'd7, 8'd4, 1'b0);
      checks++;
      if (ack !== 1'b0) begin
         errors++;
         $display("FAIL wb_busy_ack got=%b exp=0", ack);
      end
      for (int j = 0; j < 6; j++) step(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
      for (int pass = 0; pass < 2; pass++) begin
         // pass 1: write coincident with the edge must be ignored
         step(1'b1, pass == 1, 8'd9, 8'd3, 1'b0);
         checks++;
         if (ack !== 1'b0) begin
            errors++;
            $display("FAIL wb_ack_pass%0d got=%b exp=0", pass, ack);
         end
         first = -1;
         for (int j = 1; j < 8; j++) begin
            step(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
            if (pulse && first < 0) first = j;
            checks++;
            if ({pulse, busy, ack, miss} !== exp_vec()) begin
               errors++;
               $display("FAIL wb_seq pass%0d j=%0d got=%b exp=%b", pass, j,
                        {pulse, busy, ack, miss}, exp_vec());
            end
         end
         checks++;
         if (first != 2) begin
            errors++;
            $display("FAIL wb_old_delay pass%0d got=%0d exp=2", pass, first);
         end
      end
   endtask

   task automatic test_missed();
      step(1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
      step(1'b0, 1'b1, 8'd20, 8'd1, 1'b0);
      step(1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
      for (int k = 0; k < 6; k++) step(k[0], 1'b0, 8'd0, 8'd0, 1'b0);
      checks++;
      if (miss !== 8'd3) begin
         errors++;
         $display("FAIL miss_three got=%0d exp=3", miss);
      end
      for (int k = 0; k < 25; k++) step(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
      for (int k = 0; k < 700; k++) begin
         step(k[0], 1'b0, 8'd0, 8'd0, 1'b0);
         checks++;
         if ({pulse, busy, ack, miss} !== exp_vec()) begin
            errors++;
            $display("FAIL miss_seq k=%0d got=%b exp=%b", k, {pulse, busy, ack, miss}, exp_vec());
         end
      end
      checks++;
      if (miss !== 8'd255) begin
         errors++;
         $display("FAIL miss_saturate got=%0d exp=255", miss);
      end
      for (int k = 0; k < 25; k++) step(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
      step(1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
      step(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
      step(1'b1, 1'b0, 8'd0, 8'd0, 1'b1);
      checks++;
      if (miss !== 8'd0) begin
         errors++;
         $display("FAIL miss_clr_priority got=%0d exp=0", miss);
      end
      for (int k = 0; k < 25; k++) step(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
   endtask

   task automatic test_reset_mid();
      int pc, bc;
      step(1'b0, 1'b1, 8'd3, 8'd6, 1'b0);
      step(1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
      step(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
      step(1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
      step(1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
      step(1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
      checks++;
      if (pulse !== 1'b1 || miss !== 8'd1) begin
         errors++;
         $display("FAIL rm_pre got=pulse%b/miss%0d exp=pulse1/miss1", pulse, miss);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({pulse, busy, ack, miss} !== 11'd0) begin
         errors++;
         $display("FAIL rm_async_clear got=%b exp=%b", {pulse, busy, ack, miss}, 11'd0);
      end
      trig = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      step(1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
      checks++;
      if (pulse !== 1'b1) begin
         errors++;
         $display("FAIL rm_release_edge got=%b exp=1", pulse);
      end
      pc = int'(pulse); bc = int'(busy);
      for (int j = 0; j < 5; j++) begin
         step(1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
         pc += int'(pulse); bc += int'(busy);
      end
      checks++;
      if (pc != 1 || bc != 3) begin
         errors++;
         $display("FAIL rm_default_cfg got=pulse%0d/busy%0d exp=pulse1/busy3", pc, bc);
      end
   endtask

   task automatic test_random();
      bit t, wr, clr;
      logic [7:0] d, w;
      for (int k = 0; k < 500; k++) begin
         t   = $urandom_range(0, 1) == 1;
         wr  = $urandom_range(0, 7) == 0;
         clr = $urandom_range(0, 19) == 0;
         d   = 8'($urandom_range(0, 6));
         w   = 8'($urandom_range(0, 4));
         step(t, wr, d, w, clr);
         checks++;
         if ({pulse, busy, ack, miss} !== exp_vec()) begin
            errors++;
            $display("FAIL random k=%0d got=%b exp=%b", k, {pulse, busy, ack, miss}, exp_vec());
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_delay_width();
      test_width_zero();
      test_write_block();
      test_missed();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
